// File: rtl/capture_controller.sv
// capture_controller: sample-capture sequencer between the RLE encoder and
// the sample memory / output serializer.
//
// Sequence: IDLE -(arm)-> SAMPLE (circular pre-trigger fill) -(run)-> DELAY
// (post-trigger count) -> READ/READWAIT (paced readback) -> IDLE.
//
// Optional feature macro: CTRL_ARM_RESTART_EN
//   defined   : arm in any non-IDLE state restarts the capture in SAMPLE with
//               the counter cleared, and any pending send/read is dropped.
//   undefined : arm outside IDLE is ignored and the sequence runs to completion.
module capture_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        wrSize,
  input  logic [31:0] config_data,
  input  logic        validIn,
  input  logic [31:0] dataIn,
  input  logic        arm,
  input  logic        busy,
  output logic        send,
  output logic [31:0] memoryWrData,
  output logic        memoryRead,
  output logic        memoryWrite,
  output logic        memoryLastWrite
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 18;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    DELAY,
    READ,
    READWAIT
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   counterNext;
  logic [15:0]        fwd;
  logic [15:0]        bwd;
  logic [CNT_W-1:0]   fwdLast;
  logic [CNT_W-1:0]   bwdLast;

  logic               sendNext;
  logic               readNext;
  logic               writeNext;
  logic               lastWriteNext;

  // Counts are in groups of four words, so the terminal count is {n, 2'b11};
  // with n = 0xFFFF this is 0x3FFFF, which fits the 18-bit counter exactly.
  function automatic logic [CNT_W-1:0] termCount(input logic [15:0] n);
    return {n, 2'b11};
  endfunction

  function automatic logic [CNT_W-1:0] incCount(input logic [CNT_W-1:0] c);
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign fwdLast = termCount(fwd);
  assign bwdLast = termCount(bwd);

  // Size registers: loadable in any state so the host can reprogram at will.
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd <= '0;
      bwd <= '0;
    end else if (wrSize) begin
      fwd <= config_data[31:16];
      bwd <= config_data[15:0];
    end
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
    end
  end

  // Registered output stage: every strobe lags its qualifying state by one
  // cycle, and memoryWrData lags dataIn by the same cycle so they line up.
  always_ff @(posedge clock) begin
    if (reset) begin
      send            <= 1'b0;
      memoryRead      <= 1'b0;
      memoryWrite     <= 1'b0;
      memoryLastWrite <= 1'b0;
      memoryWrData    <= '0;
    end else begin
      send            <= sendNext;
      memoryRead      <= readNext;
      memoryWrite     <= writeNext;
      memoryLastWrite <= lastWriteNext;
      memoryWrData    <= dataIn[DATA_W-1:0];
    end
  end

  // Next-state, next-counter and next-strobe decode.
  always_comb begin
    stateNext     = state;
    counterNext   = counter;
    sendNext      = 1'b0;
    readNext      = 1'b0;
    writeNext     = 1'b0;
    lastWriteNext = 1'b0;

    case (state)
      IDLE: begin
        counterNext = '0;
        // arm wins over a simultaneous run; run only counts from SAMPLE
        if (arm) begin
          stateNext = SAMPLE;
        end
      end

      SAMPLE: begin
        writeNext = validIn;
        if (run) begin
          stateNext   = DELAY;
          counterNext = '0;
        end
      end

      DELAY: begin
        if (validIn) begin
          writeNext = 1'b1;
          if (counter == fwdLast) begin
            lastWriteNext = 1'b1;
            stateNext     = READ;
            counterNext   = '0;
          end else begin
            counterNext = incCount(counter);
          end
        end
      end

      READ: begin
        sendNext = 1'b1;
        readNext = 1'b1;
        if (counter == bwdLast) begin
          stateNext   = IDLE;
          counterNext = '0;
        end else begin
          stateNext   = READWAIT;
          counterNext = incCount(counter);
        end
      end

      READWAIT: begin
        // The registered send is still high the cycle after READ, which
        // gives the transmitter a cycle to raise busy before we look at it.
        if (!busy && !send) begin
          stateNext = READ;
        end
      end

      default: begin
        stateNext   = IDLE;
        counterNext = '0;
      end
    endcase

`ifdef CTRL_ARM_RESTART_EN
    // Re-arming mid-sequence restarts the pre-trigger fill from scratch;
    // writes in SAMPLE/DELAY keep following validIn, but the capture is no
    // longer terminating and no readback word is requested.
    if (arm && (state != IDLE)) begin
      stateNext     = SAMPLE;
      counterNext   = '0;
      sendNext      = 1'b0;
      readNext      = 1'b0;
      lastWriteNext = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: queue of expected memory writes, send timing
// recorded by a negedge monitor.
module tb_capture_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        wrSize = 1'b0;
  logic [31:0] config_data = '0;
  logic        validIn = 1'b0;
  logic [31:0] dataIn = '0;
  logic        arm = 1'b0;
  logic        busy = 1'b0;
  logic        send;
  logic [31:0] memoryWrData;
  logic        memoryRead;
  logic        memoryWrite;
  logic        memoryLastWrite;

  capture_controller dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .wrSize         (wrSize),
    .config_data    (config_data),
    .validIn        (validIn),
    .dataIn         (dataIn),
    .arm            (arm),
    .busy           (busy),
    .send           (send),
    .memoryWrData   (memoryWrData),
    .memoryRead     (memoryRead),
    .memoryWrite    (memoryWrite),
    .memoryLastWrite(memoryLastWrite)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] writeQ[$];
  int          sendEdges[$];
  int          writeCount = 0;
  int          lastCount = 0;
  int          lastAtWrite = 0;
  int          lastEdge = 0;
  int          sendCount = 0;
  bit          monWrData = 1'b0;
  logic [31:0] prevData = '0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) prevData <= dataIn;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (memoryWrite) begin
      writeCount++;
      if (writeQ.size() == 0) checkVal("wr_unexpected", 64'd1, 64'd0);
      else checkVal("wr_data", {32'd0, memoryWrData}, {32'd0, writeQ.pop_front()});
    end
    if (memoryLastWrite) begin
      lastCount++;
      lastAtWrite = writeCount;
      lastEdge = cyc;
      checkVal("last_with_write", {63'd0, memoryWrite}, 64'd1);
    end
    if (send || memoryRead) begin
      checkVal("read_eq_send", {63'd0, memoryRead}, {63'd0, send});
      if (send) begin
        sendCount++;
        sendEdges.push_back(cyc);
      end
    end
    if (monWrData) checkVal("wrdata_delay", {32'd0, memoryWrData}, {32'd0, prevData});
  end

  task automatic step(input bit v, input logic [31:0] d, input bit a, input bit r, input bit exw);
    validIn = v;
    dataIn = d;
    arm = a;
    run = r;
    if (v && exw) writeQ.push_back(d);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetTb();
    reset = 1'b1;
    validIn = 1'b0;
    arm = 1'b0;
    run = 1'b0;
    busy = 1'b0;
    wrSize = 1'b0;
    @(posedge clock);
    #1;
    checkVal("rst_send", {63'd0, send}, 64'd0);
    checkVal("rst_read", {63'd0, memoryRead}, 64'd0);
    checkVal("rst_write", {63'd0, memoryWrite}, 64'd0);
    checkVal("rst_last", {63'd0, memoryLastWrite}, 64'd0);
    checkVal("rst_wrdata", {32'd0, memoryWrData}, 64'd0);
    writeQ.delete();
    sendEdges.delete();
    writeCount = 0;
    lastCount = 0;
    lastAtWrite = 0;
    lastEdge = 0;
    sendCount = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic setCfg(input logic [15:0] f, input logic [15:0] b);
    config_data = {f, b};
    wrSize = 1'b1;
    @(posedge clock);
    #1;
    wrSize = 1'b0;
  endtask

  // Wait (bounded) for n sends, then confirm nothing more happens in IDLE,
  // even with validIn pulsing.
  task automatic waitSends(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && sendCount < n; i++) begin
      @(posedge clock);
      #1;
    end
    checkVal({tag, "_sends"}, sendCount, n);
    for (int i = 0; i < 12; i++) step(i[0], $urandom, 1'b0, 1'b0, 1'b0);
    checkVal({tag, "_sends_after"}, sendCount, n);
    checkVal({tag, "_pending_wr"}, writeQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int releaseEdge;

    // Reset, then validIn in IDLE must not write
    resetTb();
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkVal("idle_writes", writeCount, 0);
    checkVal("idle_sends", sendCount, 0);

    // fwd=0, bwd=0: 10 pre + 4 post writes, 4 reads spaced 3 cycles
    setCfg(16'd0, 16'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    waitSends("t2", 4, 100);
    checkVal("t2_writes", writeCount, 14);
    checkVal("t2_last_count", lastCount, 1);
    checkVal("t2_last_at", lastAtWrite, 14);
    checkVal("t2_first_read", sendEdges[0], lastEdge + 1);
    for (int i = 1; i < 4; i++) checkVal("t2_spacing", sendEdges[i] - sendEdges[i-1], 3);

    // fwd=1, bwd=2: 8 post writes, 12 reads
    resetTb();
    setCfg(16'd1, 16'd2);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    waitSends("t3", 12, 200);
    checkVal("t3_writes", writeCount, 11);
    checkVal("t3_last_count", lastCount, 1);
    checkVal("t3_last_at", lastAtWrite, 11);

    // busy held high for 20 cycles after the first send
    resetTb();
    setCfg(16'd0, 16'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    validIn = 1'b0;
    for (int i = 0; i < 50 && sendCount < 1; i++) begin
      @(posedge clock);
      #1;
    end
    checkVal("t4_first_send", sendCount, 1);
    busy = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    checkVal("t4_held_by_busy", sendCount, 1);
    busy = 1'b0;
    releaseEdge = cyc + 1;
    waitSends("t4", 8, 200);
    checkVal("t4_resume_edge", sendEdges[1], releaseEdge + 1);

    // validIn every third cycle in DELAY; memoryWrData tracks dataIn
    resetTb();
    setCfg(16'd1, 16'd0);
    monWrData = 1'b1;
    step(1'b0, $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i[0], $urandom, 1'b0, 1'b0, 1'b1);
    step(1'b0, $urandom, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) step((i % 3) == 2, $urandom, 1'b0, 1'b0, 1'b1);
    waitSends("t5", 4, 100);
    monWrData = 1'b0;
    checkVal("t5_writes", writeCount, 10);
    checkVal("t5_last_at", lastAtWrite, 10);

    // reset during READWAIT stops readback at once
    resetTb();
    setCfg(16'd0, 16'd3);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    validIn = 1'b0;
    for (int i = 0; i < 50 && sendCount < 2; i++) begin
      @(posedge clock);
      #1;
    end
    checkVal("t6_two_sends", sendCount, 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkVal("t6_send_off", {63'd0, send}, 64'd0);
    checkVal("t6_read_off", {63'd0, memoryRead}, 64'd0);
    idle(20);
    checkVal("t6_no_more_sends", sendCount, 2);
    checkVal("t6_writes", writeCount, 4);

    // arm while in DELAY
    resetTb();
    setCfg(16'd0, 16'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
`ifdef CTRL_ARM_RESTART_EN
    for (int i = 0; i < 2; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    waitSends("t7", 4, 100);
    checkVal("t7_writes", writeCount, 10);
    checkVal("t7_last_at", lastAtWrite, 10);
`else
    for (int i = 0; i < 2; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    waitSends("t7", 4, 100);
    checkVal("t7_writes", writeCount, 6);
    checkVal("t7_last_at", lastAtWrite, 6);
`endif
    checkVal("t7_last_count", lastCount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
